// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared types and constants for the SDRAM request client.
//   state_t   : client FSM states (IDLE / SYNC / REQ / WAIT)
//   byte_en_t : two-bit byte-enable, bit 1 selects the upper byte
//   DS_WORD   : byte-enable value for a full 16-bit access
// ---------------------------------------------------------------------------
package sdram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        REQ  = 2'd2,
        WAIT = 2'd3
    } state_t;

    typedef logic [1:0] byte_en_t;

    localparam byte_en_t DS_WORD = 2'b11;

endpackage

// File: rtl/sdram_req_client.sv
// ---------------------------------------------------------------------------
// sdram_req_client
// Host-side client for a toggle-handshake SDRAM controller port. A one-cycle
// host read or write strobe is latched into registered request fields and
// announced by toggling mem_req. The request is finished when mem_req_ack
// equals mem_req. Reads then wait READ_DELAY further cycles before sampling
// mem_dout into host_dout.
//
// Optional feature: define SDRAM_CLIENT_CACHE_EN to add a one-entry read
// cache. A read hitting a valid entry answers on the next cycle without any
// memory request. Without the macro every read goes to memory.
//
// Parameters
//   READ_DELAY   : cycles from the ack-match cycle to valid mem_dout (0..15)
// Ports
//   clk          : clock, all logic on the rising edge
//   init_n       : synchronous active-low reset
//   host_addr    : word address of the host access
//   host_din     : host write data
//   host_ds      : host byte enables (bit 1 = upper byte)
//   host_rd      : one-cycle read strobe
//   host_wr      : one-cycle write strobe (wins over a same-cycle read)
//   host_dout    : read data, held until the next read completes
//   host_valid   : one-cycle pulse when host_dout has been updated
//   host_busy    : strobes are ignored while high
//   mem_addr     : registered request address
//   mem_din      : registered write data
//   mem_ds       : registered byte enables (all ones for reads)
//   mem_we       : registered write flag
//   mem_req      : toggle request to the controller
//   mem_req_ack  : toggle acknowledge from the controller
//   mem_dout     : read data from the controller's port register
// ---------------------------------------------------------------------------
module sdram_req_client
    import sdram_pkg::*;
#(
    parameter int READ_DELAY = 5
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic [23:1] host_addr,
    input  logic [15:0] host_din,
    input  logic [1:0]  host_ds,
    input  logic        host_rd,
    input  logic        host_wr,
    output logic [15:0] host_dout,
    output logic        host_valid,
    output logic        host_busy,
    output logic [23:1] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_ds,
    output logic        mem_we,
    output logic        mem_req,
    input  logic        mem_req_ack,
    input  logic [15:0] mem_dout
);

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_cnt;
    logic        req_done;
    logic        accept_wr;
    logic        accept_rd;
    logic        cache_hit;

    // The handshake is level-compared, so a stale or spurious ack edge only
    // matters in states that are actually waiting for a match.
    assign req_done  = (mem_req_ack == mem_req);
    assign accept_wr = (state == IDLE) && host_wr;
    assign accept_rd = (state == IDLE) && host_rd && !host_wr;

`ifdef SDRAM_CLIENT_CACHE_EN
    logic [23:1] cache_tag;
    logic [15:0] cache_data;
    logic        cache_valid;

    assign cache_hit = cache_valid && (cache_tag == host_addr);
`else
    assign cache_hit = 1'b0;
`endif

    // State register. Reset lands in SYNC so that an acknowledge still in
    // flight from before the reset is drained before a new request is issued.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            state <= SYNC;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            SYNC: begin
                if (req_done) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (accept_wr || (accept_rd && !cache_hit)) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (req_done) begin
                    next_state = mem_we ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = SYNC;
        endcase
    end

    // Output logic: the client is busy whenever it is not idle, which makes
    // busy rise together with the request toggle and fall together with the
    // read-data pulse.
    always_comb begin
        host_busy = (state != IDLE);
    end

    // Request fields, read-data path, delay counter and optional cache.
    // A read always asks for the whole word; the host picks its bytes.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_ds      <= '0;
            mem_we      <= 1'b0;
            host_dout   <= '0;
            host_valid  <= 1'b0;
            wait_cnt    <= '0;
`ifdef SDRAM_CLIENT_CACHE_EN
            cache_tag   <= '0;
            cache_data  <= '0;
            cache_valid <= 1'b0;
`endif
        end else begin
            host_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_wr) begin
                        mem_addr <= host_addr;
                        mem_din  <= host_din;
                        mem_ds   <= host_ds;
                        mem_we   <= 1'b1;
                        mem_req  <= ~mem_req;
`ifdef SDRAM_CLIENT_CACHE_EN
                        if (cache_tag == host_addr) begin
                            cache_valid <= 1'b0;
                        end
`endif
                    end else if (accept_rd) begin
                        if (cache_hit) begin
`ifdef SDRAM_CLIENT_CACHE_EN
                            host_dout  <= cache_data;
                            host_valid <= 1'b1;
`endif
                        end else begin
                            mem_addr <= host_addr;
                            mem_din  <= host_din;
                            mem_ds   <= DS_WORD;
                            mem_we   <= 1'b0;
                            mem_req  <= ~mem_req;
                        end
                    end
                end
                REQ: begin
                    if (req_done && !mem_we) begin
                        wait_cnt <= 4'(READ_DELAY);
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        host_dout  <= mem_dout;
                        host_valid <= 1'b1;
`ifdef SDRAM_CLIENT_CACHE_EN
                        cache_tag   <= mem_addr;
                        cache_data  <= mem_dout;
                        cache_valid <= 1'b1;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_client.sv
// ---------------------------------------------------------------------------
// tb_sdram_req_client
// Two clients share the host inputs: dut_a uses the default READ_DELAY of 5,
// dut_b uses READ_DELAY 0. Each has its own toggle responder that acks three
// cycles after seeing a request toggle. Vectors give the host access and the
// expected results for both clients; hand-written sequences cover reset.
// Build with SDRAM_CLIENT_CACHE_EN defined to exercise the read cache.
// ---------------------------------------------------------------------------
module tb_sdram_req_client;

    localparam int ACK_DLY  = 3;
    localparam int RD_A     = 5;
    localparam int WIN      = 20;
    localparam int LAT_RD_A = ACK_DLY + RD_A + 3;
    localparam int LAT_RD_B = ACK_DLY + 3;
    localparam int LAT_WR   = ACK_DLY + 2;
    localparam int LAT_HIT  = 1;
`ifdef SDRAM_CLIENT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic        intrude;
        logic [23:1] addr;
        logic [15:0] din;
        logic [1:0]  ds;
        logic [15:0] rsp;
        int          exp_tog;
        logic        exp_valid;
        logic [15:0] exp_dout;
        logic        exp_we;
        logic [1:0]  exp_ds;
        logic [15:0] exp_din;
        int          exp_done_a;
        int          exp_done_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        init_n;
    logic [23:1] host_addr;
    logic [15:0] host_din;
    logic [1:0]  host_ds;
    logic        host_rd;
    logic        host_wr;
    logic [15:0] mem_dout;

    logic [15:0] host_dout_a, host_dout_b;
    logic        host_valid_a, host_valid_b;
    logic        host_busy_a, host_busy_b;
    logic [23:1] mem_addr_a, mem_addr_b;
    logic [15:0] mem_din_a, mem_din_b;
    logic [1:0]  mem_ds_a, mem_ds_b;
    logic        mem_we_a, mem_we_b;
    logic        mem_req_a, mem_req_b;
    logic        mem_req_ack_a, mem_req_ack_b;

    bit   [1:0]  rsp_seen;
    bit   [1:0]  rsp_ack;
    logic [1:0]  rsp_reqv;
    int          rsp_pend [2];
    int          tog_cnt  [2];
    bit          rsp_rst;
    bit          freeze;

    int          total = 0;
    int          bad   = 0;
    bit          exp_req = 1'b0;
    vec_t        tbl [9];
    vec_t        extra;

    always #5 clk = ~clk;

    sdram_req_client #(.READ_DELAY(RD_A)) dut_a (
        .clk(clk), .init_n(init_n),
        .host_addr(host_addr), .host_din(host_din), .host_ds(host_ds),
        .host_rd(host_rd), .host_wr(host_wr),
        .host_dout(host_dout_a), .host_valid(host_valid_a), .host_busy(host_busy_a),
        .mem_addr(mem_addr_a), .mem_din(mem_din_a), .mem_ds(mem_ds_a), .mem_we(mem_we_a),
        .mem_req(mem_req_a), .mem_req_ack(mem_req_ack_a), .mem_dout(mem_dout)
    );

    sdram_req_client #(.READ_DELAY(0)) dut_b (
        .clk(clk), .init_n(init_n),
        .host_addr(host_addr), .host_din(host_din), .host_ds(host_ds),
        .host_rd(host_rd), .host_wr(host_wr),
        .host_dout(host_dout_b), .host_valid(host_valid_b), .host_busy(host_busy_b),
        .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_ds(mem_ds_b), .mem_we(mem_we_b),
        .mem_req(mem_req_b), .mem_req_ack(mem_req_ack_b), .mem_dout(mem_dout)
    );

    assign mem_req_ack_a = rsp_ack[0];
    assign mem_req_ack_b = rsp_ack[1];

    // Responders: on the falling edge, spot a request toggle, count it, and
    // mirror it onto the ack ACK_DLY falling edges later (never while frozen).
    always @(negedge clk) begin
        rsp_reqv = {mem_req_b, mem_req_a};
        for (int i = 0; i < 2; i++) begin
            if (rsp_rst) begin
                rsp_seen[i] = 1'b0;
                rsp_ack[i]  = 1'b0;
                rsp_pend[i] = 0;
            end else if (rsp_reqv[i] != rsp_seen[i]) begin
                rsp_seen[i] = rsp_reqv[i];
                tog_cnt[i]  = tog_cnt[i] + 1;
                rsp_pend[i] = freeze ? 0 : ACK_DLY;
            end else if (rsp_pend[i] > 0) begin
                rsp_pend[i] = rsp_pend[i] - 1;
                if (rsp_pend[i] == 0) begin
                    rsp_ack[i] = rsp_seen[i];
                end
            end
        end
    end

    // One comparison: counts it, and reports it if it does not match.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one host access, watch both clients for WIN cycles, then compare.
    task automatic applyStimulus(input vec_t v, input string tag);
        int t0 [2];
        int done_c [2];
        int vcnt [2];
        int vcyc [2];
        for (int d = 0; d < 2; d++) begin
            t0[d]     = tog_cnt[d];
            done_c[d] = -1;
            vcnt[d]   = 0;
            vcyc[d]   = -1;
        end
        mem_dout = v.rsp;
        @(negedge clk);
        host_addr = v.addr;
        host_din  = v.din;
        host_ds   = v.ds;
        host_rd   = v.rd;
        host_wr   = v.wr;
        for (int k = 1; k <= WIN; k++) begin
            @(posedge clk);
            #1;
            if (done_c[0] < 0 && !host_busy_a) done_c[0] = k;
            if (done_c[1] < 0 && !host_busy_b) done_c[1] = k;
            if (host_valid_a) begin vcnt[0] = vcnt[0] + 1; vcyc[0] = k; end
            if (host_valid_b) begin vcnt[1] = vcnt[1] + 1; vcyc[1] = k; end
            if (k == 1) begin
                host_rd = 1'b0;
                host_wr = 1'b0;
                if (v.intrude) begin
                    host_wr   = 1'b1;
                    host_addr = 23'h000800;
                    host_din  = 16'hFFFF;
                    host_ds   = 2'b11;
                end
            end else if (k == 2) begin
                host_wr = 1'b0;
            end
        end
        exp_req = exp_req ^ (v.exp_tog % 2 == 1);

        checkOutput({tag, " toggles A"}, tog_cnt[0] - t0[0], v.exp_tog);
        checkOutput({tag, " toggles B"}, tog_cnt[1] - t0[1], v.exp_tog);
        checkOutput({tag, " done A"}, done_c[0], v.exp_done_a);
        checkOutput({tag, " done B"}, done_c[1], v.exp_done_b);
        checkOutput({tag, " valid count A"}, vcnt[0], v.exp_valid ? 1 : 0);
        checkOutput({tag, " valid count B"}, vcnt[1], v.exp_valid ? 1 : 0);
        if (v.exp_valid) begin
            checkOutput({tag, " valid cycle A"}, vcyc[0], v.exp_done_a);
            checkOutput({tag, " valid cycle B"}, vcyc[1], v.exp_done_b);
        end
        checkOutput({tag, " dout A"}, host_dout_a, v.exp_dout);
        checkOutput({tag, " dout B"}, host_dout_b, v.exp_dout);
        checkOutput({tag, " mem_addr A"}, mem_addr_a, v.addr);
        checkOutput({tag, " mem_addr B"}, mem_addr_b, v.addr);
        checkOutput({tag, " mem_we A"}, mem_we_a, v.exp_we);
        checkOutput({tag, " mem_ds A"}, mem_ds_a, v.exp_ds);
        checkOutput({tag, " mem_din A"}, mem_din_a, v.exp_din);
        checkOutput({tag, " mem_req A"}, mem_req_a, exp_req);
        checkOutput({tag, " mem_req B"}, mem_req_b, exp_req);
    endtask

    initial begin
        // rd wr intr addr din ds rsp | tog valid dout we ds din doneA doneB
        tbl[0] = '{1'b1, 1'b0, 1'b0, 23'h001234, 16'h0000, 2'b11, 16'hBEEF,
                   1, 1'b1, 16'hBEEF, 1'b0, 2'b11, 16'h0000, LAT_RD_A, LAT_RD_B};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 23'h000100, 16'h00A5, 2'b01, 16'h0BAD,
                   1, 1'b0, 16'hBEEF, 1'b1, 2'b01, 16'h00A5, LAT_WR, LAT_WR};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 23'h000010, 16'h0000, 2'b11, 16'h1111,
                   1, 1'b1, 16'h1111, 1'b0, 2'b11, 16'h0000, LAT_RD_A, LAT_RD_B};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 23'h000010, 16'h0000, 2'b11, 16'h2222,
                   CACHE ? 0 : 1, 1'b1, CACHE ? 16'h1111 : 16'h2222, 1'b0, 2'b11, 16'h0000,
                   CACHE ? LAT_HIT : LAT_RD_A, CACHE ? LAT_HIT : LAT_RD_B};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 23'h000010, 16'h5A5A, 2'b10, 16'h0BAD,
                   1, 1'b0, CACHE ? 16'h1111 : 16'h2222, 1'b1, 2'b10, 16'h5A5A, LAT_WR, LAT_WR};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 23'h000010, 16'h0000, 2'b11, 16'h3333,
                   1, 1'b1, 16'h3333, 1'b0, 2'b11, 16'h0000, LAT_RD_A, LAT_RD_B};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 23'h000200, 16'h1234, 2'b11, 16'h0BAD,
                   1, 1'b0, 16'h3333, 1'b1, 2'b11, 16'h1234, LAT_WR, LAT_WR};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 23'h7FFFFF, 16'h0000, 2'b01, 16'hA5A5,
                   1, 1'b1, 16'hA5A5, 1'b0, 2'b11, 16'h0000, LAT_RD_A, LAT_RD_B};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 23'h000400, 16'h0000, 2'b11, 16'h4444,
                   1, 1'b1, 16'h4444, 1'b0, 2'b11, 16'h0000, LAT_RD_A, LAT_RD_B};

        init_n    = 1'b0;
        rsp_rst   = 1'b1;
        freeze    = 1'b0;
        host_addr = '0;
        host_din  = '0;
        host_ds   = '0;
        host_rd   = 1'b0;
        host_wr   = 1'b0;
        mem_dout  = '0;
        tog_cnt[0] = 0;
        tog_cnt[1] = 0;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy A", host_busy_a, 1);
        checkOutput("reset busy B", host_busy_b, 1);
        checkOutput("reset mem_req A", mem_req_a, 0);
        checkOutput("reset valid A", host_valid_a, 0);
        checkOutput("reset dout A", host_dout_a, 0);
        checkOutput("reset mem_addr A", mem_addr_a, 0);
        init_n  = 1'b1;
        rsp_rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("sync exit busy A", host_busy_a, 0);
        checkOutput("sync exit busy B", host_busy_b, 0);

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i], $sformatf("v%0d", i));
        end

        $display("[TB] reset during an outstanding request");
        if (!exp_req) begin
            extra = '{1'b0, 1'b1, 1'b0, 23'h000A00, 16'h0000, 2'b11, 16'h0BAD,
                      1, 1'b0, 16'h4444, 1'b1, 2'b11, 16'h0000, LAT_WR, LAT_WR};
            applyStimulus(extra, "parity write");
        end
        freeze = 1'b1;
        @(negedge clk);
        host_addr = 23'h000900;
        host_din  = 16'hC0DE;
        host_ds   = 2'b11;
        host_wr   = 1'b1;
        @(posedge clk);
        #1;
        host_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stalled busy A", host_busy_a, 1);
        checkOutput("stalled busy B", host_busy_b, 1);
        checkOutput("stalled mem_req A", mem_req_a, 0);
        @(negedge clk);
        init_n = 1'b0;
        @(posedge clk);
        #1;
        init_n = 1'b1;
        checkOutput("mid reset mem_req A", mem_req_a, 0);
        checkOutput("mid reset mem_addr A", mem_addr_a, 0);
        checkOutput("mid reset mem_din A", mem_din_a, 0);
        checkOutput("mid reset mem_we A", mem_we_a, 0);
        checkOutput("mid reset mem_ds A", mem_ds_a, 0);
        checkOutput("mid reset dout A", host_dout_a, 0);
        checkOutput("mid reset busy A", host_busy_a, 1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("sync hold busy A", host_busy_a, 1);
        checkOutput("sync hold busy B", host_busy_b, 1);
        rsp_rst = 1'b1;
        freeze  = 1'b0;
        @(posedge clk);
        #1;
        rsp_rst = 1'b0;
        checkOutput("sync release busy A", host_busy_a, 0);
        checkOutput("sync release busy B", host_busy_b, 0);
        exp_req = 1'b0;

        extra = '{1'b1, 1'b0, 1'b0, 23'h000040, 16'h0000, 2'b11, 16'h7777,
                  1, 1'b1, 16'h7777, 1'b0, 2'b11, 16'h0000, LAT_RD_A, LAT_RD_B};
        applyStimulus(extra, "post reset read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
